// File: rtl/bitwise_gate_pipe.sv
// bitwise_gate_pipe: two-stage valid/ready pipeline that applies one of eight
// bitwise gates (AND/OR/NAND/NOR/XOR/XNOR/NOT a/BUF a) to a and b.
// Stage 1 registers the operands and op. Stage 2 registers the result and its op.
// Optional macro GATE_XFER_CNT_EN builds a wrapping counter of output transfers
// on xfer_cnt. When the macro is undefined, xfer_cnt is tied to zero.
module bitwise_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;

    // Bitwise gate selected by sel. The NOT a and BUF a codes ignore b.
    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] ga,
                                              input logic [WIDTH-1:0] gb,
                                              input logic [2:0]       sel);
        case (sel)
            OP_AND:  return ga & gb;
            OP_OR:   return ga | gb;
            OP_NAND: return ~(ga & gb);
            OP_NOR:  return ~(ga | gb);
            OP_XOR:  return ga ^ gb;
            OP_XNOR: return ~(ga ^ gb);
            OP_NOTA: return ~ga;
            default: return ga;
        endcase
    endfunction

    logic             s1_v;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_v;
    logic [WIDTH-1:0] y_q;
    logic [2:0]       op_q;
    logic             s2_adv;

    // Stage 2 can take new content when it is empty or its result leaves now.
    assign s2_adv    = ~s2_v | out_ready;
    // Stage 1 can take new content when it is empty or it moves into stage 2 now.
    // in_ready is held low while reset is asserted.
    assign in_ready  = rst_n & (~s1_v | s2_adv);
    assign out_valid = s2_v;
    assign y         = y_q;
    assign out_op    = op_q;

    // Stage 1 occupancy. It refills from the input or empties as its content moves on.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses non-blocking assignment, so all stages
        // sample the values from before the edge and the pipeline shifts cleanly.
        if (!rst_n) begin
            s1_v <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
        end
    end

    // Stage 1 operand capture. Only an actual input transfer changes these registers.
    always_ff @(posedge clk) begin
        // NOTE: these data registers have no reset. s1_v qualifies them, so
        // their contents after reset do not matter.
        if (in_valid && in_ready) begin
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
        end
    end

    // Stage 2 computes the result and holds it steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            y_q  <= '0;
            op_q <= 3'b000;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                y_q  <= gate(s1_a, s1_b, s1_op);
                op_q <= s1_op;
            end
        end
    end

`ifdef GATE_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count completed output transfers. The counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s2_v && out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: doc/bitwise_gate_pipe.md
BITWISE_GATE_PIPE -- requirements
Module: bitwise_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream presents a, b, op.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  gate select.
REQ-010 out_valid  output  1  y and out_op hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 y  output  WIDTH  bitwise gate result.
REQ-013 out_op  output  3  op value that produced y.
REQ-014 xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 Op encoding SHALL be: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 BUF a (b ignored); applied bitwise across all WIDTH bits.
REQ-016 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-017 Datapath SHALL be a two-stage register pipeline: stage 1 captures a, b, op; stage 2 holds computed y and op.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid high when out_ready is held high.
REQ-019 Throughput SHALL be one transfer per cycle with out_ready held high.
REQ-020 Stage 2 SHALL load from stage 1 when stage 2 is empty or its result transfers in the same cycle.
REQ-021 Stage 1 SHALL load when empty or when its content moves to stage 2 in the same cycle.
REQ-022 in_ready SHALL be high iff stage 1 is empty or stage 1 advances this cycle (combinational from out_ready allowed).
REQ-023 While out_valid && !out_ready, y and out_op SHALL remain stable; no result SHALL be dropped or duplicated.
REQ-024 Pipeline full (both stages valid, out_ready low) SHALL drive in_ready low.
REQ-025 Simultaneous input and output transfer on a full pipeline SHALL shift both stages and accept the new input in one cycle.
REQ-026 Results SHALL leave in input order.
REQ-027 a, b, op values on cycles without an input transfer SHALL have no effect on state.

Reset
REQ-028 rst_n low at a rising edge SHALL clear both stage valid flags, y to 0, out_op to 000, xfer_cnt to 0.
REQ-029 in_ready SHALL be low while rst_n is low and high on the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results; no output transfer SHALL follow for discarded data.

Configuration
REQ-031 Macro GATE_XFER_CNT_EN defined: xfer_cnt SHALL increment by 1 on each output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-032 Macro GATE_XFER_CNT_EN undefined: xfer_cnt port SHALL remain present, tied to 0, no counter register built.

Verification
REQ-033 WIDTH=8, out_ready=1, inputs a=8'hF0, b=8'hCC for ops 000..111 on consecutive cycles -> y = 8'hC0, FC, 3F, 03, 3C, C3, 0F, F0 respectively, each 2 cycles after its input, out_op matching.
REQ-034 WIDTH=1 exhaustive a,b in {00,01,10,11} with op=NAND -> y = 1,1,1,0 in order (single-bit regression of the original gate).
REQ-035 Stream 6 inputs with out_ready=0 -> exactly 2 accepted, in_ready low from cycle 2; raise out_ready -> all 6 results in order, none lost.
REQ-036 Random out_ready toggling over 1000 transactions with random a, b, op -> every y matches model, order preserved, y stable while stalled.
REQ-037 rst_n low for 1 cycle with both stages valid -> out_valid=0, y=0, xfer_cnt=0 next cycle; no stale output after release.
REQ-038 With GATE_XFER_CNT_EN, CNT_W=4, 17 output transfers -> xfer_cnt=1; without the macro -> xfer_cnt=0 throughout.
